// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral register bus.
// Contents: address/data widths, register offsets, highest mapped address,
// bus-master FSM state encoding and an address legality helper.
package periph_bus_pkg;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  // Register byte offsets on the peripheral bus.
  localparam logic [AW-1:0] DIN    = 5'd0;
  localparam logic [AW-1:0] DOUT   = 5'd4;
  localparam logic [AW-1:0] TIMER0 = 5'd8;
  localparam logic [AW-1:0] TIMER1 = 5'd12;
  localparam logic [AW-1:0] PWM0   = 5'd16;
  localparam logic [AW-1:0] OUTM   = 5'd20;
  localparam logic [AW-1:0] SEG7   = 5'd24;
  localparam logic [AW-1:0] A_MAX  = SEG7;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  // Word-aligned and within the mapped register range.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && (a <= A_MAX);
  endfunction

endpackage

// File: rtl/periph_bus_master_if.sv
// Signal bundle for periph_bus_master.
// master modport: the bus master's view (command in, response out, bus out, RD in).
// slave modport : the opposite view, used by the command source / bus target side.
interface periph_bus_master_if;
  import periph_bus_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we;
  logic [3:0]    cmd_len;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_last;

  logic [AW-1:0] A;
  logic [DW-1:0] WD;
  logic          WE;
  logic [DW-1:0] RD;

  logic          busy;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_we, cmd_len,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_last,
    input  rsp_ready,
    output A, WD, WE,
    input  RD,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_we, cmd_len,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_last,
    output rsp_ready,
    input  A, WD, WE,
    output RD,
    input  busy
  );

endinterface

// File: rtl/periph_bus_master.sv
// Peripheral bus initiator: accepts single/burst commands, issues one bus beat
// at a time (one ISSUE cycle each) and returns one response per beat.
// Ports: clk, rst (async, active-high), bus (periph_bus_master_if.master):
//   cmd_* handshake in, rsp_* handshake out, A/WD/WE/RD word bus, busy.
// Optional macro PERIPH_BUS_MASTER_ADDR_CHECK_EN: reject unaligned or unmapped
// beats (no WE, rdata 0, rsp_err 1); otherwise every beat is issued, rsp_err=0.
module periph_bus_master
  import periph_bus_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  periph_bus_master_if.master  bus
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [3:0]    remaining_q, remaining_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          last_q, last_d;
  logic          beat_ok;

`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
  logic err_q, err_d;
  assign beat_ok     = addr_ok(addr_q);
  assign bus.rsp_err = err_q;
`else
  assign beat_ok     = 1'b1;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      remaining_q <= '0;
      rdata_q     <= '0;
      last_q      <= 1'b0;
`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      remaining_q <= remaining_d;
      rdata_q     <= rdata_d;
      last_q      <= last_d;
`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    remaining_d = remaining_q;
    rdata_d     = rdata_q;
    last_d      = last_q;
`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          addr_d      = bus.cmd_addr;
          wdata_d     = bus.cmd_wdata;
          we_d        = bus.cmd_we;
          remaining_d = bus.cmd_len;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        // Writes and rejected beats return zero; reads capture the settled RD.
        rdata_d = (we_q || !beat_ok) ? '0 : bus.RD;
        last_d  = (remaining_q == 4'd0);
`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
        err_d   = !beat_ok;
`endif
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          if (remaining_q == 4'd0) begin
            state_d = StIdle;
          end else begin
            addr_d      = addr_q + 5'd4;  // wraps modulo 32
            remaining_d = remaining_q - 4'd1;
            state_d     = StIssue;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // cmd_ready is gated by rst so it reads 0 for the whole reset assertion.
  assign bus.cmd_ready = (state_q == StIdle) && !rst;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_last  = last_q;
  assign bus.A         = addr_q;
  assign bus.WD        = wdata_q;
  assign bus.WE        = (state_q == StIssue) && we_q && beat_ok;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_periph_bus_master.sv
module tb_periph_bus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  periph_bus_master_if bif ();

  periph_bus_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  // Combinational register-file model for the bus target.
  logic [31:0] mem [8];
  assign bif.RD = mem[bif.A[4:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        last;
    logic        wen;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  int we_cnt = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] a, input logic we, input logic last);
    exp_t e;
    logic bad = 1'b0;
`ifdef PERIPH_BUS_MASTER_ADDR_CHECK_EN
    bad = (a[1:0] != 2'b00) || (a > 5'd24);
`endif
    e.err   = bad;
    e.rdata = (we || bad) ? 32'h0 : mem[a[4:2]];
    e.last  = last;
    e.wen   = we && !bad;
    return e;
  endfunction

  // Push one expectation per beat; return how many WE cycles the command should make.
  task automatic push_cmd(input logic [4:0] a, input logic we, input logic [3:0] len,
                          output int nwe);
    exp_t e;
    logic [4:0] ai;
    nwe = 0;
    for (int i = 0; i <= int'(len); i++) begin
      ai = a + 5'(i * 4);
      e = model(ai, we, i == int'(len));
      if (e.wen) nwe++;
      sb.push_back(e);
    end
  endtask

  // Monitor: sample mid-cycle, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bif.busy && !bif.rsp_valid) issue_cnt++;
        if (bif.WE) we_cnt++;
        if (bif.rsp_valid && !bif.rsp_ready) chk("we_while_stalled", 32'(bif.WE), 32'd0);
        if (bif.cmd_valid && bif.cmd_ready) begin
          acc_cnt++;
          chk("accept_when_idle", 32'(bif.busy), 32'd0);
        end
        if (bif.rsp_valid && bif.rsp_ready) begin
          rsp_cnt++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL rsp_unexpected got rdata %h exp no response", bif.rsp_rdata);
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", bif.rsp_rdata, e.rdata);
            chk("rsp_err", 32'(bif.rsp_err), 32'(e.err));
            chk("rsp_last", 32'(bif.rsp_last), 32'(e.last));
          end
        end
      end
    end
  end

  // Offer a command, wait for acceptance, check ISSUE and first-response latency.
  task automatic send_cmd(input logic [4:0] a, input logic [31:0] wd, input logic we,
                          input logic [3:0] len);
    int n = 0;
    exp_t e0;
    e0 = model(a, we, len == 4'd0);
    bif.cmd_addr  = a;
    bif.cmd_wdata = wd;
    bif.cmd_we    = we;
    bif.cmd_len   = len;
    bif.cmd_valid = 1'b1;
    while (!bif.cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_ready_timeout", 32'(bif.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    chk("issue_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("issue_busy", 32'(bif.busy), 32'd1);
    chk("issue_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    chk("issue_A", 32'(bif.A), 32'(a));
    chk("issue_WD", bif.WD, wd);
    chk("issue_WE", 32'(bif.WE), 32'(e0.wen));
    @(posedge clk); #1;
    chk("first_rsp_valid", 32'(bif.rsp_valid), 32'd1);
  endtask

  // Drive rsp_ready from a repeating 4-cycle pattern until the master is idle.
  task automatic wait_idle(input logic [3:0] pat);
    int n = 0;
    while (bif.busy && n < 300) begin
      bif.rsp_ready = pat[n % 4];
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(bif.busy), 32'd0);
    bif.rsp_ready = 1'b1;
  endtask

  initial begin
    int i0, w0, r0, a0, nwe, nwe2, n;
    bif.cmd_valid = 1'b0;
    bif.cmd_addr  = '0;
    bif.cmd_wdata = '0;
    bif.cmd_we    = 1'b0;
    bif.cmd_len   = '0;
    bif.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000_0000 + 32'(i * 32'h111);
    mem[0] = 32'h0000_A5A5;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bif.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bif.rsp_err), 32'd0);
    chk("rst_rsp_last", 32'(bif.rsp_last), 32'd0);
    chk("rst_A", 32'(bif.A), 32'd0);
    chk("rst_WD", bif.WD, 32'd0);
    chk("rst_WE", 32'(bif.WE), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_cmd_ready", 32'(bif.cmd_ready), 32'd1);

    // Single read.
    i0 = issue_cnt; w0 = we_cnt; r0 = rsp_cnt;
    push_cmd(5'd0, 1'b0, 4'd0, nwe);
    send_cmd(5'd0, 32'h0, 1'b0, 4'd0);
    wait_idle(4'b1111);
    chk("rd_issues", 32'(issue_cnt - i0), 32'd1);
    chk("rd_we_cycles", 32'(we_cnt - w0), 32'd0);
    chk("rd_rsps", 32'(rsp_cnt - r0), 32'd1);

    // Single write.
    i0 = issue_cnt; w0 = we_cnt; r0 = rsp_cnt;
    push_cmd(5'd4, 1'b1, 4'd0, nwe);
    send_cmd(5'd4, 32'h000F_00FF, 1'b1, 4'd0);
    wait_idle(4'b1111);
    chk("wr_we_cycles", 32'(we_cnt - w0), 32'(nwe));
    chk("wr_rsps", 32'(rsp_cnt - r0), 32'd1);

    // Read burst with rsp_ready stalls; 28 is the last beat.
    i0 = issue_cnt; w0 = we_cnt; r0 = rsp_cnt;
    push_cmd(5'd16, 1'b0, 4'd3, nwe);
    send_cmd(5'd16, 32'h0, 1'b0, 4'd3);
    wait_idle(4'b1001);
    chk("burst_issues", 32'(issue_cnt - i0), 32'd4);
    chk("burst_rsps", 32'(rsp_cnt - r0), 32'd4);
    chk("burst_we_cycles", 32'(we_cnt - w0), 32'd0);
    chk("burst_A_final", 32'(bif.A), 32'd28);

    // Wrap across 28 -> 0 on a two-beat read.
    r0 = rsp_cnt;
    push_cmd(5'd28, 1'b0, 4'd1, nwe);
    send_cmd(5'd28, 32'h0, 1'b0, 4'd1);
    wait_idle(4'b1111);
    chk("wrap_A_final", 32'(bif.A), 32'd0);
    chk("wrap_rsps", 32'(rsp_cnt - r0), 32'd2);

    // Unaligned / out-of-range write (rejected only with the address check).
    i0 = issue_cnt; w0 = we_cnt; r0 = rsp_cnt;
    push_cmd(5'd26, 1'b1, 4'd1, nwe);
    send_cmd(5'd26, 32'hDEAD_BEEF, 1'b1, 4'd1);
    wait_idle(4'b1111);
    chk("chk_issues", 32'(issue_cnt - i0), 32'd2);
    chk("chk_we_cycles", 32'(we_cnt - w0), 32'(nwe));
    chk("chk_rsps", 32'(rsp_cnt - r0), 32'd2);

    // Reset during ISSUE of beat 2 of a write burst.
    push_cmd(5'd0, 1'b1, 4'd5, nwe);
    bif.cmd_addr = 5'd0; bif.cmd_wdata = 32'h1234_5678; bif.cmd_we = 1'b1;
    bif.cmd_len = 4'd5; bif.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_beat2_WE", 32'(bif.WE), 32'd1);
    chk("mid_beat2_A", 32'(bif.A), 32'd4);
    rst = 1'b1;
    #1;
    chk("mid_rst_WE", 32'(bif.WE), 32'd0);
    chk("mid_rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bif.busy), 32'd0);
    chk("mid_rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(bif.rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(bif.busy), 32'd0);
    end

    // cmd_valid held high across two commands.
    a0 = acc_cnt; r0 = rsp_cnt;
    push_cmd(5'd8, 1'b0, 4'd1, nwe);
    push_cmd(5'd20, 1'b0, 4'd0, nwe2);
    bif.rsp_ready = 1'b1;
    bif.cmd_addr = 5'd8; bif.cmd_we = 1'b0; bif.cmd_len = 4'd1; bif.cmd_valid = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hyg_accept1", 32'(acc_cnt - a0), 32'd1);
    bif.cmd_addr = 5'd20; bif.cmd_len = 4'd0;
    n = 0;
    while (acc_cnt == a0 + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    bif.cmd_valid = 1'b0;
    chk("hyg_accept2_after_last", 32'(rsp_cnt - r0), 32'd2);
    wait_idle(4'b1111);
    chk("hyg_accepts", 32'(acc_cnt - a0), 32'd2);
    chk("hyg_rsps", 32'(rsp_cnt - r0), 32'd3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
